// File: rtl/rtc_bus_rw_fsm.sv
// rtc_bus_rw_fsm
// Bus-cycle sequencer for a multiplexed address/data peripheral bus, such as
// an external RTC with an Intel-style AD bus. Each start request runs one
// complete transaction: an address phase, an idle gap, and a data phase
// (write or read). This is followed by a recovery gap. The FSM then waits
// for the request to be released before it can start another transaction.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   w_r        transaction type (1 = write, 0 = read), latched at start
//   do_it      level-sensitive start request, one transaction per assertion
//   a_d        address/data select (0 = address phase, 1 = data/idle)
//   cs         chip select, active low
//   rd         read strobe, active low
//   wr         write strobe, active low
//   read_data  one-cycle pulse: datapath latches bus data (read only)
//   send_data  datapath drives write data onto the bus
//   send_add   datapath drives the address onto the bus
module rtc_bus_rw_fsm #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic w_r,
  input  logic do_it,
  output logic a_d,
  output logic cs,
  output logic rd,
  output logic wr,
  output logic read_data,
  output logic send_data,
  output logic send_add
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    RECOVER,
    WAIT_REL
  } state_t;

  localparam int MAXT = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(T_GAP - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          is_write, is_write_nxt;

  logic a_d_nxt, cs_nxt, rd_nxt, wr_nxt;
  logic read_data_nxt, send_data_nxt, send_add_nxt;

  // State, phase counter, latched type and the bus outputs all live in
  // flops. The outputs are decoded from the next-state values and then
  // registered. Each output therefore matches the state it belongs to in the
  // same cycle, and comes straight from a flop, so it cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      a_d       <= 1'b1;
      cs        <= 1'b1;
      rd        <= 1'b1;
      wr        <= 1'b1;
      read_data <= 1'b0;
      send_data <= 1'b0;
      send_add  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      is_write  <= is_write_nxt;
      a_d       <= a_d_nxt;
      cs        <= cs_nxt;
      rd        <= rd_nxt;
      wr        <= wr_nxt;
      read_data <= read_data_nxt;
      send_data <= send_data_nxt;
      send_add  <= send_add_nxt;
    end
  end

  // Next-state logic. The counter counts down to zero within each timed
  // phase. It is reloaded with (length - 1) on every state change, so a
  // phase lasts exactly its programmed number of cycles. The transaction
  // type is captured only on the IDLE -> ADDR edge. As a result, changes
  // to w_r or do_it mid-transaction have no effect.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    is_write_nxt = is_write;
    case (state)
      IDLE: begin
        if (do_it) begin
          state_nxt    = ADDR;
          cnt_nxt      = PULSE_LD;
          is_write_nxt = w_r;
        end
      end
      ADDR: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = DATA;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          state_nxt = RECOVER;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_nxt = WAIT_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_REL: begin
        if (!do_it) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode for the upcoming cycle. wr is also pulled low during the
  // address phase, as the bus protocol requires. read_data fires only in
  // the final DATA cycle of a read, when the counter is about to expire.
  always_comb begin
    a_d_nxt       = 1'b1;
    cs_nxt        = 1'b1;
    rd_nxt        = 1'b1;
    wr_nxt        = 1'b1;
    read_data_nxt = 1'b0;
    send_data_nxt = 1'b0;
    send_add_nxt  = 1'b0;
    case (state_nxt)
      ADDR: begin
        a_d_nxt      = 1'b0;
        cs_nxt       = 1'b0;
        wr_nxt       = 1'b0;
        send_add_nxt = 1'b1;
      end
      DATA: begin
        cs_nxt = 1'b0;
        if (is_write_nxt) begin
          wr_nxt        = 1'b0;
          send_data_nxt = 1'b1;
        end else begin
          rd_nxt        = 1'b0;
          read_data_nxt = (cnt_nxt == '0);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_rw_fsm.sv
// tb_rtc_bus_rw_fsm
// Directed testbench for rtc_bus_rw_fsm using the default parameters
// (T_PULSE = 10, T_GAP = 5). Cycle n is the clock period following edge
// n-1, where edge 0 is the edge that samples do_it = 1. Outputs are observed
// on the falling edge. They are compared as the packed vector
// {a_d, cs, rd, wr, read_data, send_data, send_add}.
module tb_rtc_bus_rw_fsm;

  logic clk;
  logic reset;
  logic w_r;
  logic do_it;
  logic a_d, cs, rd, wr, read_data, send_data, send_add;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] V_IDLE  = 7'b1111000;
  localparam logic [6:0] V_ADDR  = 7'b0010001;
  localparam logic [6:0] V_WDATA = 7'b1010010;
  localparam logic [6:0] V_RDATA = 7'b1001000;
  localparam logic [6:0] V_RLAST = 7'b1001100;

  rtc_bus_rw_fsm #(.T_PULSE(10), .T_GAP(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_r       (w_r),
    .do_it     (do_it),
    .a_d       (a_d),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .read_data (read_data),
    .send_data (send_data),
    .send_add  (send_add)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector for cycle c of a transaction of the given type.
  function automatic logic [6:0] exp_vec(input int c, input bit wt);
    logic [6:0] v;
    v = V_IDLE;
    if (c >= 1 && c <= 10) v = V_ADDR;
    else if (c >= 16 && c <= 25) begin
      if (wt) v = V_WDATA;
      else v = (c == 25) ? V_RLAST : V_RDATA;
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic t, input logic go);
    reset = r;
    w_r   = t;
    do_it = go;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {a_d, cs, rd, wr, read_data, send_data, send_add};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Starts a transaction on the next rising edge. It checks cycles 1..ncyc.
  // do_it is dropped once `hold` edges have sampled it high. When tog is
  // set, w_r is flipped during the GAP phase.
  task automatic run_txn(input string name, input bit wt, input int hold,
                         input int ncyc, input bit tog);
    applyStimulus(1'b0, wt, 1'b1);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_c%0d", name, c), exp_vec(c, wt));
      if (c >= hold) do_it = 1'b0;
      if (tog && c == 12) w_r = ~w_r;
    end
  endtask

  // Directed test sequence.
  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_%0d", i), V_IDLE);
    end

    $display("[TB] write transaction, do_it held through reset release");
    reset = 1'b0;
    #1 checkOutput("rel", V_IDLE);
    run_txn("wr", 1'b1, 3, 34, 1'b0);

    $display("[TB] read transaction");
    run_txn("rd", 1'b0, 3, 34, 1'b0);

    $display("[TB] do_it held for 60 cycles, then a single-cycle pulse");
    run_txn("hold", 1'b1, 60, 64, 1'b0);
    run_txn("again", 1'b0, 1, 34, 1'b0);

    $display("[TB] w_r toggled during the gap of a write");
    run_txn("tog", 1'b1, 3, 34, 1'b1);

    $display("[TB] reset asserted during the data phase");
    run_txn("pre", 1'b1, 3, 20, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("async_rst", V_IDLE);
    do_it = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("in_rst_%0d", i), V_IDLE);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_%0d", i), V_IDLE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_rw_fsm.md
Name: rtc_bus_rw_fsm

Overview:
- Bus-cycle sequencer for a multiplexed address/data parallel peripheral bus, such as an external RTC with Intel-style AD bus.
- On a start request it runs one complete transaction: an address phase, then a data phase, which is either a write or a read.
- Drives the active-low bus strobes plus three steering flags used by the surrounding datapath: drive address, drive data, capture data.
- Sits between the controller logic that requests accesses and the tri-state bus I/O block.

Parameters:
- T_PULSE, 10: clock cycles each strobe phase (address, data) is held active; must be >= 2.
- T_GAP, 5: clock cycles of idle bus between address and data phases, and after the data phase (recovery); must be >= 1.

Ports:
- clk, input, 1: system clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- w_r, input, 1: transaction type; 1 = write, 0 = read. Sampled only when a transaction starts.
- do_it, input, 1: start request, level-sensitive. One transaction per assertion.
- a_d, output, 1: address/data select; 0 = address phase, 1 = data/idle.
- cs, output, 1: chip select, active-low.
- rd, output, 1: read strobe, active-low.
- wr, output, 1: write strobe, active-low.
- read_data, output, 1: one-cycle pulse telling the datapath to latch bus data (read only).
- send_data, output, 1: high while the datapath must drive write data onto the bus.
- send_add, output, 1: high while the datapath must drive the address onto the bus.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction): state IDLE, phase counter 0, latched type 0. Outputs immediately take idle levels: a_d=1, cs=1, rd=1, wr=1, read_data=0, send_data=0, send_add=0. While reset is high, do_it is ignored.
- Outputs are Moore: decoded only from the state register, phase counter and latched type. They are never combinational from inputs and must be glitch-free.
- States and outputs (anything not listed = idle level):
  - IDLE: idle levels.
  - ADDR: a_d=0, cs=0, wr=0, send_add=1. Lasts T_PULSE cycles.
  - GAP: idle levels. Lasts T_GAP cycles.
  - DATA: cs=0, a_d=1. If write: wr=0, send_data=1. If read: rd=0, and read_data=1 in the last DATA cycle only. Lasts T_PULSE cycles.
  - RECOVER: idle levels. Lasts T_GAP cycles.
  - WAIT_REL: idle levels. Remains until do_it=0.
- Transitions:
  - IDLE -> ADDR on the clock edge where do_it=1. The same edge latches w_r into the internal type register.
  - ADDR -> GAP -> DATA -> RECOVER -> WAIT_REL, each after its phase count expires. The counter reloads at every state change.
  - WAIT_REL -> IDLE on the first edge with do_it=0. If do_it is already 0 when RECOVER ends, the FSM spends exactly one cycle in WAIT_REL and then returns to IDLE.
- Latency with defaults, counting edge 0 as the edge that samples do_it=1:
  - ADDR is active for cycles 1–10.
  - GAP for cycles 11–15.
  - DATA for cycles 16–25; read_data pulses in cycle 25.
  - RECOVER for cycles 26–30.
  - WAIT_REL from cycle 31.
  - Total 31 cycles before a new start is possible.
- w_r and do_it changes during a transaction have no effect. The transaction cannot be aborted except by reset.
- rd and wr are never both low. cs is low only in ADDR and DATA.
- send_add and send_data are never both high.
- do_it held high continuously yields exactly one transaction.
- do_it asserted during reset and still high after reset release starts a transaction on the first edge after release.

Test Plan:
- Reset with w_r=1, do_it=1 for 10 cycles -> all outputs at idle levels (a_d=1, cs=rd=wr=1, flags 0) for the whole reset interval.
- Release reset, hold do_it=1 for 3 cycles then 0, with w_r=1 -> 10 cycles of a_d=0/cs=0/wr=0/send_add=1; 5 idle cycles; 10 cycles of cs=0/wr=0/send_data=1 with rd=1; back to IDLE by cycle 32; read_data never 1.
- Same sequence with w_r=0 -> identical address phase; data phase with rd=0, wr=1, send_data=0; read_data high exactly 1 cycle (cycle 25).
- do_it held high for 60 cycles -> exactly one transaction; bus stays idle until do_it falls; a new do_it pulse starts a second transaction.
- Toggle w_r during a write transaction's GAP -> data phase still a write (wr=0, rd=1).
- Assert reset during DATA -> outputs return to idle levels asynchronously, before the next clock edge; after release with do_it=0 the FSM stays IDLE.
